instr_loader: RTL and testbench

- Writer side of the CPU instruction-write port (`wr_instr_en` / `wr_instr`).
- Accepts a framed byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit instruction words and emits one single-cycle write pulse per word.
- Checks a frame checksum, reports load status, and gates `cpu_run_o` so the core executes only after a clean load.

---
 rtl/instr_loader.sv | 122 ++++++++++++
 tb/tb_instr_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: framed byte stream to CPU instruction-write port with checksum and run gating
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   byte_valid_i, byte_i     incoming stream byte (valid/ready)
//   byte_ready_o             always ready outside reset
//   wr_instr_en_o/wr_instr_o single-cycle instruction write strobe and word
//   word_cnt_o               words written in the current or last frame
//   load_done_o, load_err_o  sticky status of the last frame
//   cpu_run_o                CPU release, equal to load_done_o
module instr_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 1024,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        wr_instr_en_o,
    output logic [31:0] wr_instr_o,
    output logic [15:0] word_cnt_o,
    output logic        load_done_o,
    output logic        load_err_o,
    output logic        cpu_run_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] MAXW = 16'(MAX_WORDS);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} state_t;

    state_t        r_state, w_next;
    logic [15:0]   r_len, r_cnt;
    logic [1:0]    r_idx;
    logic [31:0]   r_asm, r_wr;
    logic [7:0]    r_csum;
    logic [TW-1:0] r_to;
    logic          r_wr_en, r_done, r_err;
    logic [15:0]   w_len;
    logic          w_timeout, w_last;

    assign w_len     = {byte_i, r_len[7:0]};
    // counter reaches TIMEOUT_CYCLES on the edge of this idle cycle
    assign w_timeout = (r_state != IDLE) && !byte_valid_i && (r_to == TO_LAST);
    assign w_last    = (r_idx == 2'd3) && (r_cnt + 16'd1 == r_len);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) w_next = IDLE;
        else if (byte_valid_i)
            case (r_state)
                IDLE:    w_next = (byte_i == SYNC_BYTE) ? LEN0 : IDLE;
                LEN0:    w_next = LEN1;
                LEN1:    w_next = (w_len > MAXW) ? IDLE : (w_len == 16'd0) ? CSUM : DATA;
                DATA:    w_next = w_last ? CSUM : DATA;
                default: w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_wr    <= '0;
            r_csum  <= '0;
            r_to    <= '0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_to    <= (r_state == IDLE || byte_valid_i) ? '0 : r_to + 1'b1;
            if (w_timeout) r_err <= 1'b1;
            if (byte_valid_i)
                case (r_state)
                    IDLE: if (byte_i == SYNC_BYTE) begin
                        r_cnt  <= '0;
                        r_idx  <= '0;
                        r_csum <= '0;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                    LEN0: r_len[7:0] <= byte_i;
                    LEN1: begin
                        r_len <= w_len;
                        if (w_len > MAXW) r_err <= 1'b1;
                    end
                    DATA: begin
                        r_asm[{r_idx, 3'b000} +: 8] <= byte_i;
                        r_csum <= r_csum ^ byte_i;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_wr_en <= 1'b1;
                            r_wr    <= {byte_i, r_asm[23:0]};
                            r_cnt   <= r_cnt + 16'd1;
                        end
                    end
                    CSUM: begin
                        r_done <= (byte_i == r_csum);
                        r_err  <= (byte_i != r_csum);
                    end
                    default: ;
                endcase
        end
    end

    assign byte_ready_o  = rst_ni;
    assign wr_instr_en_o = r_wr_en;
    assign wr_instr_o    = r_wr;
    assign word_cnt_o    = r_cnt;
    assign load_done_o   = r_done;
    assign load_err_o    = r_err;
    assign cpu_run_o     = r_done;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader with directed frames
module tb_instr_loader;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_ready_o, wr_instr_en_o, load_done_o, load_err_o, cpu_run_o;
    logic [31:0] wr_instr_o;
    logic [15:0] word_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  f[$];

    instr_loader #(.SYNC_BYTE(8'hA5), .MAX_WORDS(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
        .byte_ready_o(byte_ready_o), .wr_instr_en_o(wr_instr_en_o), .wr_instr_o(wr_instr_o),
        .word_cnt_o(word_cnt_o), .load_done_o(load_done_o), .load_err_o(load_err_o),
        .cpu_run_o(cpu_run_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every strobe must match the next expected word
    always @(negedge clk_i) begin
        if (rst_ni && wr_instr_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %h expected none", wr_instr_o);
            end else begin
                chk("wr_instr", wr_instr_o, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_i = b;
        @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic sendq(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic status(input string name, input logic [15:0] cnt, input logic done, input logic err);
        chk({name, "_cnt"}, 32'(word_cnt_o), 32'(cnt));
        chk({name, "_done"}, 32'(load_done_o), 32'(done));
        chk({name, "_err"}, 32'(load_err_o), 32'(err));
        chk({name, "_run"}, 32'(cpu_run_o), 32'(done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("reset_en", 32'(wr_instr_en_o), 0);
        chk("reset_wr", wr_instr_o, 0);
        status("reset", 16'd0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        idle(1);
        chk("ready", 32'(byte_ready_o), 1);

        // good 2-word frame, checksum 13^93^10 = 90
        exp_q.push_back(32'h00000013);
        exp_q.push_back(32'h00100093);
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        sendq(f);
        idle(2);
        status("good", 16'd2, 1'b1, 1'b0);

        // bad checksum; status cleared as soon as sync is seen
        exp_q.push_back(32'h00000013);
        exp_q.push_back(32'h00100093);
        send(8'hA5);
        status("inframe", 16'd0, 1'b0, 1'b0);
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h84};
        sendq(f);
        idle(2);
        status("badcsum", 16'd2, 1'b0, 1'b1);

        // garbage then empty frame
        f = '{8'h00, 8'hFF, 8'h3C};
        sendq(f);
        idle(2);
        status("garbage", 16'd2, 1'b0, 1'b1);
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        sendq(f);
        idle(1);
        status("empty", 16'd0, 1'b1, 1'b0);

        // oversize length 1025, trailing bytes ignored
        f = '{8'hA5, 8'h01, 8'h04};
        sendq(f);
        status("oversize", 16'd0, 1'b0, 1'b1);
        f = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        sendq(f);
        idle(2);
        status("ovr_tail", 16'd0, 1'b0, 1'b1);

        // timeout after 16 idle cycles, then recovery
        f = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        sendq(f);
        idle(15);
        status("to_15", 16'd0, 1'b0, 1'b0);
        idle(1);
        status("to_16", 16'd0, 1'b0, 1'b1);
        send(8'h00);
        exp_q.push_back(32'h00001237);
        f = '{8'hA5, 8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
        sendq(f);
        idle(2);
        status("recover", 16'd1, 1'b1, 1'b0);

        // reset during the second word of a 2-word frame
        exp_q.push_back(32'h00000013);
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        sendq(f);
        chk("pre_rst_cnt", 32'(word_cnt_o), 1);
        byte_valid_i = 1'b1;
        byte_i = 8'h10;
        #1 rst_ni = 1'b0;
        #1;
        chk("async_wr", wr_instr_o, 0);
        chk("async_en", 32'(wr_instr_en_o), 0);
        status("async", 16'd0, 1'b0, 1'b0);
        byte_valid_i = 1'b0;
        #4 rst_ni = 1'b1;
        f = '{8'h00, 8'h10, 8'h00, 8'h83, 8'h13, 8'h00, 8'h00, 8'h00};
        sendq(f);
        idle(2);
        status("post_rst", 16'd0, 1'b0, 1'b0);

        chk("pending_words", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
